// File: rtl/bitwise_map_pkg.sv
// Shared types and pure helpers for the bitwise map engine: op encoding,
// FSM states, the element-wise operation and the single-flag condition check.
package bitwise_map_pkg;

    localparam int BM_MAX_W = 64;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_ANDN = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_COPY = 3'd7
    } bitmap_op_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_EVAL, ST_READ, ST_WAIT, ST_WRITE, ST_FIN
    } bitmap_state_e;

    // Words up to BM_MAX_W bits; callers zero-extend and truncate the result.
    function automatic logic [BM_MAX_W-1:0] bitmap_apply(input bitmap_op_e op,
                                                        input logic [BM_MAX_W-1:0] a,
                                                        input logic [BM_MAX_W-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_ANDN: return a & ~b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            default: return b;
        endcase
    endfunction

    function automatic logic cond_eval(input logic uncond, input logic flag, input logic inv);
        return uncond | (flag ^ inv);
    endfunction

endpackage

// File: rtl/bitmap_alu.sv
// Combinational element-wise operator; one instance per lane.
module bitmap_alu
    import bitwise_map_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  bitmap_op_e        op_i,
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    output logic [WORD_W-1:0] y_o
);

    assign y_o = WORD_W'(bitmap_apply(op_i, BM_MAX_W'(a_i), BM_MAX_W'(b_i)));

endmodule

// File: rtl/bitwise_map_engine.sv
// Sequential map engine: mem[origin+i] = op(mem[origin+i], mem[modifier+i]),
// one word at a time, reads and writes strictly alternating.
module bitwise_map_engine
    import bitwise_map_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int LEN_W     = 11,
    parameter int NUM_FLAGS = 8,
    parameter int RD_LAT    = 1,
    localparam int FSEL_W   = $clog2(NUM_FLAGS) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    output logic                 ready_o,
    input  logic [2:0]           op_i,
    input  logic [ADDR_W-1:0]    origin_i,
    input  logic [ADDR_W-1:0]    modifier_i,
    input  logic [LEN_W-1:0]     length_i,
    input  logic [FSEL_W-1:0]    flag_sel_i,
    input  logic                 flag_inv_i,
    input  logic [NUM_FLAGS-1:0] flags_i,
    output logic [ADDR_W-1:0]    rd_a_addr_o,
    output logic [ADDR_W-1:0]    rd_b_addr_o,
    output logic                 rd_en_o,
    input  logic [WORD_W-1:0]    rd_a_data_i,
    input  logic [WORD_W-1:0]    rd_b_data_i,
    output logic                 wr_en_o,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic [WORD_W-1:0]    wr_data_o,
    output logic                 done_o,
    output logic                 skipped_o,
    output logic [LEN_W-1:0]     words_done_o
);

    typedef struct packed {
        bitmap_op_e          op;
        logic [ADDR_W-1:0]   origin;
        logic [ADDR_W-1:0]   modifier;
        logic [LEN_W-1:0]    length;
        logic [FSEL_W-1:0]   flag_sel;
        logic                flag_inv;
    } bitmap_args_t;

    bitmap_state_e       state_q;
    bitmap_args_t        args_q;
    logic [LEN_W-1:0]    idx_q;
    logic [LEN_W-1:0]    words_q;
    logic                ready_q, rd_en_q, wr_en_q, done_q, skipped_q;
    logic [ADDR_W-1:0]   rd_a_addr_q, rd_b_addr_q, wr_addr_q;
    logic [LEN_W-1:0]    idx_nxt;
    logic                cond;
    logic [WORD_W-1:0]   alu_y;

    assign idx_nxt = idx_q + 1'b1;
    assign cond    = cond_eval(args_q.flag_sel[FSEL_W-1],
                               flags_i[args_q.flag_sel[FSEL_W-2:0]], args_q.flag_inv);

    bitmap_alu #(.WORD_W(WORD_W)) u_alu (
        .op_i (args_q.op),
        .a_i  (rd_a_data_i),
        .b_i  (rd_b_data_i),
        .y_o  (alu_y)
    );

    // Read data is only valid during WRITE, so the write data stays combinational.
    assign wr_data_o    = wr_en_q ? alu_y : '0;
    assign ready_o      = ready_q;
    assign rd_en_o      = rd_en_q;
    assign rd_a_addr_o  = rd_a_addr_q;
    assign rd_b_addr_o  = rd_b_addr_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign done_o       = done_q;
    assign skipped_o    = skipped_q;
    assign words_done_o = words_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            args_q      <= '0;
            idx_q       <= '0;
            words_q     <= '0;
            ready_q     <= 1'b1;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            skipped_q   <= 1'b0;
            rd_a_addr_q <= '0;
            rd_b_addr_q <= '0;
            wr_addr_q   <= '0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: if (start_i) begin
                    args_q    <= '{op: bitmap_op_e'(op_i), origin: origin_i, modifier: modifier_i,
                                   length: length_i, flag_sel: flag_sel_i, flag_inv: flag_inv_i};
                    idx_q     <= '0;
                    words_q   <= '0;
                    skipped_q <= 1'b0;
                    ready_q   <= 1'b0;
                    state_q   <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (!cond) begin
                        skipped_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= ST_FIN;
                    end else if (args_q.length == '0) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        rd_en_q     <= 1'b1;
                        rd_a_addr_q <= args_q.origin;
                        rd_b_addr_q <= args_q.modifier;
                        state_q     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (RD_LAT == 2) begin
                        state_q <= ST_WAIT;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= rd_a_addr_q;
                        state_q   <= ST_WRITE;
                    end
                end
                ST_WAIT: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= rd_a_addr_q;
                    state_q   <= ST_WRITE;
                end
                ST_WRITE: begin
                    words_q <= words_q + 1'b1;
                    if (idx_nxt == args_q.length) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        idx_q       <= idx_nxt;
                        rd_en_q     <= 1'b1;
                        rd_a_addr_q <= args_q.origin + ADDR_W'(idx_nxt);
                        rd_b_addr_q <= args_q.modifier + ADDR_W'(idx_nxt);
                        state_q     <= ST_READ;
                    end
                end
                ST_FIN: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_map_engine.sv
// Scoreboard bench: two engines (RD_LAT=1/ADDR_W=10 and RD_LAT=2/ADDR_W=4)
// over behavioural RAMs; expected writes are queued at launch and popped on wr_en.
module tb_bitwise_map_engine;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_bad = 0;
    int dcnt = 0;

    logic        sel = 1'b0, start = 1'b0;
    logic [2:0]  op = '0;
    logic [9:0]  origin = '0, modifier = '0;
    logic [10:0] length = '0;
    logic [3:0]  flag_sel = 4'b1000;
    logic        flag_inv = 1'b0;
    logic [7:0]  flags = '0;

    logic        ready1, rd_en1, wr_en1, done1, skipped1;
    logic [9:0]  ra_addr1, rb_addr1, wa1;
    logic [31:0] ra_d1, rb_d1, wd1;
    logic [10:0] wdn1;
    logic        ready2, rd_en2, wr_en2, done2, skipped2;
    logic [3:0]  ra_addr2, rb_addr2, wa2;
    logic [31:0] ra_d2, rb_d2, wd2, p2a, p2b;
    logic [10:0] wdn2;

    bitwise_map_engine #(.ADDR_W(10), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start & ~sel), .ready_o(ready1), .op_i(op),
        .origin_i(origin), .modifier_i(modifier), .length_i(length), .flag_sel_i(flag_sel),
        .flag_inv_i(flag_inv), .flags_i(flags), .rd_a_addr_o(ra_addr1), .rd_b_addr_o(rb_addr1),
        .rd_en_o(rd_en1), .rd_a_data_i(ra_d1), .rd_b_data_i(rb_d1), .wr_en_o(wr_en1),
        .wr_addr_o(wa1), .wr_data_o(wd1), .done_o(done1), .skipped_o(skipped1), .words_done_o(wdn1));

    bitwise_map_engine #(.ADDR_W(4), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start & sel), .ready_o(ready2), .op_i(op),
        .origin_i(origin[3:0]), .modifier_i(modifier[3:0]), .length_i(length), .flag_sel_i(flag_sel),
        .flag_inv_i(flag_inv), .flags_i(flags), .rd_a_addr_o(ra_addr2), .rd_b_addr_o(rb_addr2),
        .rd_en_o(rd_en2), .rd_a_data_i(ra_d2), .rd_b_data_i(rb_d2), .wr_en_o(wr_en2),
        .wr_addr_o(wa2), .wr_data_o(wd2), .done_o(done2), .skipped_o(skipped2), .words_done_o(wdn2));

    // Behavioural RAMs, plus a one-word preload port driven by the stimulus.
    logic        pl = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem1 [1024];
    logic [31:0] mem2 [16];
    logic [31:0] shadow1 [1024];
    logic [31:0] shadow2 [16];

    always @(posedge clk) begin
        if (pl && !sel) mem1[pl_addr] <= pl_data;
        else if (wr_en1) mem1[wa1] <= wd1;
        if (rd_en1) begin ra_d1 <= mem1[ra_addr1]; rb_d1 <= mem1[rb_addr1]; end
        if (pl && sel) mem2[pl_addr[3:0]] <= pl_data;
        else if (wr_en2) mem2[wa2] <= wd2;
        if (rd_en2) begin p2a <= mem2[ra_addr2]; p2b <= mem2[rb_addr2]; end
        ra_d2 <= p2a;
        rb_d2 <= p2b;
    end

    logic        v_ready, v_wr_en, v_done, v_skipped;
    logic [9:0]  v_wa;
    logic [31:0] v_wd;
    logic [10:0] v_wdn;
    assign v_ready   = sel ? ready2 : ready1;
    assign v_wr_en   = sel ? wr_en2 : wr_en1;
    assign v_done    = sel ? done2 : done1;
    assign v_skipped = sel ? skipped2 : skipped1;
    assign v_wa      = sel ? {6'd0, wa2} : wa1;
    assign v_wd      = sel ? wd2 : wd1;
    assign v_wdn     = sel ? wdn2 : wdn1;

    logic [41:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (v_wr_en) begin
            if (exp_q.size() == 0) chk("extra_write", 64'(exp_q.size()), 64'd1);
            else chk("write", {v_wa, v_wd}, exp_q.pop_front());
        end
        if (v_done) dcnt <= dcnt + 1;
    end

    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return a & ~b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return b;
        endcase
    endfunction

    // In-order reference: each word sees all earlier writes of the same op.
    task automatic model(input int n);
        for (int i = 0; i < n; i++) begin
            int ad, bd;
            logic [31:0] r;
            if (sel) begin
                ad = (int'(origin) + i) % 16; bd = (int'(modifier) + i) % 16;
                r = ref_op(op, shadow2[ad], shadow2[bd]); shadow2[ad] = r;
            end else begin
                ad = (int'(origin) + i) % 1024; bd = (int'(modifier) + i) % 1024;
                r = ref_op(op, shadow1[ad], shadow1[bd]); shadow1[ad] = r;
            end
            exp_q.push_back({10'(ad), r});
        end
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge clk);
        pl = 1'b1; pl_addr = 10'(a); pl_data = d;
        if (sel) shadow2[a % 16] = d; else shadow1[a] = d;
        @(negedge clk);
        pl = 1'b0;
    endtask

    task automatic fill(input int base, input int n);
        for (int i = 0; i < n; i++) preload(base + i, $urandom);
    endtask

    task automatic run(input logic sk, input logic hold);
        int n, lat, cyc, rdy_hi;
        n   = sk ? 0 : int'(length);
        lat = (n == 0) ? 2 : (sel ? 3 : 2) * n + 2;
        model(n);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = hold;
        cyc = 1; rdy_hi = 0;
        while (!v_done && cyc < 400) begin
            if (v_ready) rdy_hi++;
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        chk("done_cycle", 64'(cyc), 64'(lat));
        chk("skipped", 64'(v_skipped), 64'(sk));
        chk("words_done", 64'(v_wdn), 64'(n));
        if (hold) chk("ready_while_busy", 64'(rdy_hi), 64'd0);
        @(negedge clk);
        chk("ready_after", 64'(v_ready), 64'd1);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    logic [31:0] op_tbl [8] = '{32'h05050505, 32'hAFAFAFAF, 32'hAAAAAAAA, 32'hA0A0A0A0,
                                32'hFAFAFAFA, 32'h50505050, 32'h55555555, 32'h0F0F0F0F};
    logic [31:0] base_a [4] = '{32'hF0F0F0F0, 32'hFFFFFFFF, 32'h12345678, 32'h00000000};
    logic [31:0] base_b [4] = '{32'hFF00FF00, 32'h0000FFFF, 32'hFFFFFFFF, 32'hDEADBEEF};
    logic [31:0] base_e [4] = '{32'hF000F000, 32'h0000FFFF, 32'h12345678, 32'h00000000};

    initial begin
        int seen, k, d0;
        repeat (3) @(negedge clk);
        chk("rst_ready1", 64'(ready1), 64'd1);
        chk("rst_ready2", 64'(ready2), 64'd1);
        chk("rst_strobes", {rd_en1, wr_en1, done1, skipped1, rd_en2, wr_en2, done2}, 64'd0);
        chk("rst_outs", {ra_addr1, rb_addr1, wa1, wd1, wdn1}, 64'd0);
        rst_n = 1'b1;

        // Baseline AND
        for (int i = 0; i < 4; i++) begin preload(i, base_a[i]); preload(8 + i, base_b[i]); end
        op = 3'd0; origin = 10'd0; modifier = 10'd8; length = 11'd4; flag_sel = 4'b1000;
        run(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk("base_mem", 64'(mem1[i]), 64'(base_e[i]));

        // Every op on one word
        for (int o = 0; o < 8; o++) begin
            preload(100, 32'hA5A5A5A5); preload(200, 32'h0F0F0F0F);
            op = 3'(o); origin = 10'd100; modifier = 10'd200; length = 11'd1;
            run(1'b0, 1'b0);
            chk("op_result", 64'(mem1[100]), 64'(op_tbl[o]));
        end

        // Conditional gating
        op = 3'd2; length = 11'd2; fill(100, 2); fill(200, 2);
        flag_sel = 4'd3; flags = 8'h00; flag_inv = 1'b0;
        run(1'b1, 1'b0);
        flag_inv = 1'b1;
        run(1'b0, 1'b0);
        flags = 8'h08; flag_inv = 1'b0;
        run(1'b0, 1'b0);
        flag_sel = 4'b1000;

        // Overlapping ranges: copy propagates word 50 forward
        preload(50, 32'h11111111); preload(51, 32'h22222222);
        preload(52, 32'h33333333); preload(53, 32'h44444444);
        op = 3'd7; origin = 10'd51; modifier = 10'd50; length = 11'd3;
        run(1'b0, 1'b0);
        chk("overlap_mem", 64'(mem1[53]), 64'h11111111);

        // Zero length, then start held through a 5-word op
        length = 11'd0;
        run(1'b0, 1'b0);
        fill(400, 5); fill(410, 5);
        op = 3'd1; origin = 10'd400; modifier = 10'd410; length = 11'd5;
        run(1'b0, 1'b1);

        // Reset after the second write of a 6-word op
        fill(300, 6); fill(310, 6);
        op = 3'd2; origin = 10'd300; modifier = 10'd310; length = 11'd6;
        model(2);
        d0 = dcnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0; k = 0;
        while (seen < 2 && k < 100) begin
            @(negedge clk); k++;
            if (wr_en1) seen++;
        end
        chk("writes_before_rst", 64'(seen), 64'd2);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready1), 64'd1);
        chk("midrst_strobes", {rd_en1, wr_en1, done1, skipped1}, 64'd0);
        chk("midrst_outs", {ra_addr1, rb_addr1, wa1, wd1, wdn1}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_done", 64'(dcnt), 64'(d0));
        chk("midrst_pending", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 6; i++) chk("midrst_mem", 64'(mem1[300 + i]), 64'(shadow1[300 + i]));
        length = 11'd2;
        run(1'b0, 1'b0);

        // RD_LAT=2, ADDR_W=4: wrap-around copy, then a longer AND
        sel = 1'b1;
        preload(14, 32'hAAAA0014); preload(15, 32'hBBBB0015);
        preload(0, 32'hCCCC0000); preload(1, 32'hDDDD0001);
        op = 3'd7; origin = 10'd14; modifier = 10'd15; length = 11'd3;
        run(1'b0, 1'b0);
        chk("wrap_m14", 64'(mem2[14]), 64'hBBBB0015);
        chk("wrap_m15", 64'(mem2[15]), 64'hCCCC0000);
        chk("wrap_m0", 64'(mem2[0]), 64'hDDDD0001);
        fill(2, 8);
        op = 3'd0; origin = 10'd2; modifier = 10'd6; length = 11'd4;
        run(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/bitwise_map_engine.md
Name: bitwise_map_engine

Overview:
- Sequential, parametrised successor to the single-shot AND map.
- Over a word-addressed execution-environment memory it applies a selectable bitwise operation element-wise: mem[origin+i] = op(mem[origin+i], mem[modifier+i]) for i = 0..length-1.
- Execution is gated by a single-flag conditional.
- Sits between the instruction decoder (start/argument handshake) and the shared u32 environment RAM (one read-pair port, one write port).

Parameters:
- WORD_W, 32, data word width.
- ADDR_W, 10, word address width; environment depth 2**ADDR_W.
- LEN_W, 11, width of length argument (allows full-depth maps).
- NUM_FLAGS, 8, number of condition flags visible to the engine.
- RD_LAT, 1, RAM read latency in cycles (1 or 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted when start && ready
- ready  out  1  engine idle, can accept start
- op  in  3  0 AND, 1 OR, 2 XOR, 3 ANDN(A&~B), 4 NAND, 5 NOR, 6 XNOR, 7 COPY(B)
- origin  in  ADDR_W  destination/first operand base
- modifier  in  ADDR_W  second operand base
- length  in  LEN_W  element count
- flag_sel  in  $clog2(NUM_FLAGS)+1  MSB=1 means unconditional; else index into flags
- flag_inv  in  1  invert selected flag
- flags  in  NUM_FLAGS  live condition flags
- rd_a_addr  out  ADDR_W  operand A address
- rd_b_addr  out  ADDR_W  operand B address
- rd_en  out  1  read strobe
- rd_a_data  in  WORD_W  A data, valid RD_LAT cycles after rd_en
- rd_b_data  in  WORD_W  B data, valid RD_LAT cycles after rd_en
- wr_en  out  1  write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  WORD_W  write data
- done  out  1  one-cycle pulse at completion
- skipped  out  1  valid with done; 1 if condition false
- words_done  out  LEN_W  count of words written in last/current operation

Behaviour:
- Reset (async assert, sync deassert assumed at system level): state IDLE.
- Reset values: ready=1; rd_en, wr_en, done, skipped=0; words_done=0; all address/data outputs 0.
- FSM states: IDLE, EVAL, READ, WAIT, WRITE, FIN.
- IDLE -> EVAL on accepted start.
  - op, origin, modifier, length, flag_sel and flag_inv are latched.
  - ready drops the following cycle.
  - words_done clears to 0.
- EVAL: cond = flag_sel MSB ? 1 : flags[flag_sel] ^ flag_inv; flags are sampled in this cycle only.
  - cond=0 -> FIN with skipped=1.
  - length=0 -> FIN with skipped=0.
  - Otherwise -> READ with index i=0.
- READ: rd_en=1, rd_a_addr=origin+i, rd_b_addr=modifier+i, sums mod 2**ADDR_W (wrap-around is legal, no error). Next state is WAIT if RD_LAT=2, else WRITE.
- WAIT: idle one cycle, then WRITE.
- WRITE: wr_en=1, wr_addr=origin+i, wr_data=op(rd_a_data, rd_b_data); words_done increments.
  - If i+1 == length -> FIN.
  - Else i++ and -> READ.
- Throughput: one word per 2 cycles (RD_LAT=1) or 3 cycles (RD_LAT=2). Reads and writes never overlap, so overlapping ranges get strict in-order semantics: word i reads memory after all writes j<i.
- FIN: done=1 for exactly one cycle, then IDLE with ready=1.
- Latency with RD_LAT=1, from accept edge: L>0 -> done asserted in cycle 2L+2; skip or L=0 -> cycle 2.
- start while busy is ignored; it is not queued.
- Argument changes while busy have no effect.
- Reset mid-operation: returns to IDLE immediately. Writes already issued remain; no further writes; done does not pulse.
- op values map exactly as listed. All operations are bitwise over WORD_W; no carries.

Decomposition:
- Shared package bitwise_map_pkg:
  - op enum bitmap_op_e
  - FSM state enum
  - an argument struct {op, origin, modifier, length, flag_sel, flag_inv}
  - pure function bitmap_apply(op, a, b)
- The conditional-flag check reuses the existing single-flag conditional package function.
- One natural sub-module: bitmap_alu (combinational, WORD_W-parametrised, wraps bitmap_apply) so it can be unit-tested and reused by a future multi-lane variant.

Test Plan:
- Baseline AND, RD_LAT=1: mem[0..3]={F0F0F0F0,FFFFFFFF,12345678,0}, mem[8..11]={FF00FF00,0000FFFF,FFFFFFFF,DEADBEEF}, op=0, origin=0, modifier=8, length=4, unconditional -> mem[0..3]={F000F000,0000FFFF,12345678,0}; done in cycle 10; words_done=4; skipped=0.
- Op coverage: A=0xA5A5A5A5, B=0x0F0F0F0F, length=1, op 0..7 -> 05050505, AFAFAFAF, AAAAAAAA, A0A0A0A0, FAFAFAFA, 50505050, 55555555, 0F0F0F0F.
- Conditional gating: flag_sel=3, flags=8'h00, flag_inv=0 -> no wr_en ever, done in cycle 2, skipped=1. Repeat with flag_inv=1 -> writes occur, skipped=0.
- Overlap and wrap: ADDR_W=4, origin=14, modifier=15, length=3, op=7 (COPY) -> word i reads post-write memory; writes go to addresses 14, 15, 0 in order (wrap-around).
- Boundary and handshake: length=0 -> done in cycle 2, no writes. start held high during a 5-word op -> exactly one op executes; ready=0 throughout. RD_LAT=2 run -> done in cycle 3L+2.
- Reset mid-operation: assert rst_n=0 after the 2nd write of a length=6 op -> outputs take reset values asynchronously; only 2 words modified; no done; next start runs normally.
